// File: rtl/fsm_ctrl_pkg.sv
// rtl/fsm_ctrl_pkg.sv - shared state encodings and helpers for the detector arbiter
package fsm_ctrl_pkg;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2
    } det_state_e;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_STREAM = 2'd1,
        ARB_REPORT = 2'd2
    } arb_state_e;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_detector_core.sv
// rtl/seq_detector_core.sv - 3-state Moore sequence detector with clear and bit enable
module seq_detector_core
    import fsm_ctrl_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic en,
    input  logic bit_in,
    output logic det_out,
    output logic detect
);

    det_state_e state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = S0;
        end else if (en) begin
            case (state_q)
                S0:      state_d = bit_in ? S1 : S0;
                S1:      state_d = bit_in ? S1 : S2;
                S2:      state_d = bit_in ? S0 : S2;
                default: state_d = S0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    assign det_out = (state_q == S2);
    // Detection is the S1->S2 step, flagged in the same cycle the bit is consumed
    assign detect  = en & ~clear & (state_q == S1) & ~bit_in;

endmodule

// File: rtl/detector_arbiter.sv
// rtl/detector_arbiter.sv - round-robin share of one sequence detector; optional DETECT_TIMEOUT_EN stall watchdog
module detector_arbiter
    import fsm_ctrl_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = 8
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ-1:0]           req_bit,
    input  logic [N_REQ-1:0]           req_last,
    output logic [N_REQ-1:0]           req_ready,
    output logic [N_REQ-1:0]           grant,
    output logic                       busy,
    output logic                       done_valid,
    output logic [$clog2(N_REQ)-1:0]   done_id,
    output logic [CNT_W-1:0]           done_count,
    output logic                       done_timeout
);

    localparam int ID_W = id_width(N_REQ);

    arb_state_e        state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [ID_W-1:0]   cur_id_q, cur_id_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              done_valid_q, done_valid_d;
    logic [ID_W-1:0]   done_id_q, done_id_d;
    logic [CNT_W-1:0]  done_count_q, done_count_d;

    logic              pick_found;
    logic [ID_W-1:0]   pick_id;
    logic [ID_W-1:0]   pick_try;
    int                pick_idx;

    logic              g_valid, g_bit, g_last, consume;
    logic              det_clear, detect, det_out;
    logic              timeout_hit, finish;
    logic              unused_det;

`ifdef DETECT_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT + 1);
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               done_timeout_q, done_timeout_d;
`else
    localparam int unused_timeout = TIMEOUT;
`endif

    // Round-robin search starts just after the last reported owner
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        pick_try   = '0;
        pick_idx   = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            pick_idx = (int'(rr_ptr_q) + k) % N_REQ;
            pick_try = pick_idx[ID_W-1:0];
            if (!pick_found && req_valid[pick_try]) begin
                pick_found = 1'b1;
                pick_id    = pick_try;
            end
        end
    end

    assign g_valid   = |(req_valid & grant_q);
    assign g_bit     = |(req_bit & grant_q);
    assign g_last    = |(req_last & grant_q);
    assign consume   = (state_q == ARB_STREAM) & g_valid;
    assign det_clear = (state_q == ARB_IDLE);

    seq_detector_core u_det (
        .clk     (CLK),
        .resetn  (RST),
        .clear   (det_clear),
        .en      (consume),
        .bit_in  (g_bit),
        .det_out (det_out),
        .detect  (detect)
    );

    assign unused_det = det_out;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        cur_id_d     = cur_id_q;
        rr_ptr_d     = rr_ptr_q;
        count_d      = count_q;
        done_valid_d = 1'b0;
        done_id_d    = done_id_q;
        done_count_d = done_count_q;
        timeout_hit  = 1'b0;
        finish       = 1'b0;
`ifdef DETECT_TIMEOUT_EN
        stall_d        = stall_q;
        done_timeout_d = done_timeout_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                count_d = '0;
`ifdef DETECT_TIMEOUT_EN
                stall_d = '0;
`endif
                if (pick_found) begin
                    grant_d  = {{(N_REQ-1){1'b0}}, 1'b1} << pick_id;
                    cur_id_d = pick_id;
                    state_d  = ARB_STREAM;
                end
            end
            ARB_STREAM: begin
                if (detect && (count_q != {CNT_W{1'b1}})) begin
                    count_d = count_q + CNT_W'(1);
                end
`ifdef DETECT_TIMEOUT_EN
                if (consume) begin
                    stall_d = '0;
                end else begin
                    stall_d = stall_q + STALL_W'(1);
                    if (stall_d == STALL_W'(TIMEOUT)) begin
                        timeout_hit = 1'b1;
                    end
                end
`endif
                finish = (consume & g_last) | timeout_hit;
                if (finish) begin
                    state_d      = ARB_REPORT;
                    grant_d      = '0;
                    rr_ptr_d     = cur_id_q;
                    done_valid_d = 1'b1;
                    done_id_d    = cur_id_q;
                    done_count_d = count_d;
`ifdef DETECT_TIMEOUT_EN
                    done_timeout_d = timeout_hit;
`endif
                end
            end
            ARB_REPORT: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q      <= ARB_IDLE;
            grant_q      <= '0;
            cur_id_q     <= '0;
            rr_ptr_q     <= ID_W'(N_REQ - 1);
            count_q      <= '0;
            done_valid_q <= 1'b0;
            done_id_q    <= '0;
            done_count_q <= '0;
`ifdef DETECT_TIMEOUT_EN
            stall_q        <= '0;
            done_timeout_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            cur_id_q     <= cur_id_d;
            rr_ptr_q     <= rr_ptr_d;
            count_q      <= count_d;
            done_valid_q <= done_valid_d;
            done_id_q    <= done_id_d;
            done_count_q <= done_count_d;
`ifdef DETECT_TIMEOUT_EN
            stall_q        <= stall_d;
            done_timeout_q <= done_timeout_d;
`endif
        end
    end

    assign grant      = grant_q;
    assign req_ready  = grant_q;
    assign busy       = (state_q != ARB_IDLE);
    assign done_valid = done_valid_q;
    assign done_id    = done_id_q;
    assign done_count = done_count_q;
`ifdef DETECT_TIMEOUT_EN
    assign done_timeout = done_timeout_q;
`else
    assign done_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_detector_arbiter.sv
// tb/tb_detector_arbiter.sv - directed self-checking bench for detector_arbiter
module tb_detector_arbiter;

    localparam int N_REQ   = 4;
    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 8;

    logic              CLK = 1'b0;
    logic              RST;
    logic [N_REQ-1:0]  req_valid, req_bit, req_last;
    logic [N_REQ-1:0]  req_ready, grant;
    logic              busy, done_valid, done_timeout;
    logic [1:0]        done_id;
    logic [CNT_W-1:0]  done_count;

    int   checks = 0;
    int   errors = 0;
    int   done_n = 0;
    int   base;
    logic [1:0] d_id  [0:31];
    logic [3:0] d_cnt [0:31];
    logic       d_to  [0:31];
    logic       overlap = 1'b0;

    always #5 CLK = ~CLK;

    detector_arbiter #(
        .N_REQ   (N_REQ),
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .req_valid    (req_valid),
        .req_bit      (req_bit),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .grant        (grant),
        .busy         (busy),
        .done_valid   (done_valid),
        .done_id      (done_id),
        .done_count   (done_count),
        .done_timeout (done_timeout)
    );

    // Records every done pulse and watches for overlapping grants
    always @(posedge CLK) begin
        #2;
        if (done_valid) begin
            if (done_n < 32) begin
                d_id[done_n]  = done_id;
                d_cnt[done_n] = done_count;
                d_to[done_n]  = done_timeout;
            end
            done_n = done_n + 1;
        end
        if (!$onehot0(grant)) overlap = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic [1:0] id, input logic b, input logic last);
        int n;
        n = 0;
        req_valid[id] = 1'b1;
        req_bit[id]   = b;
        req_last[id]  = last;
        while (!req_ready[id] && n < 60) begin
            @(negedge CLK);
            n = n + 1;
        end
        check("ready_wait", {31'd0, req_ready[id]}, 32'd1);
        @(negedge CLK);
        req_valid[id] = 1'b0;
        req_last[id]  = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_n < target && n < 40) begin
            @(negedge CLK);
            n = n + 1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        RST       = 1'b0;
        req_valid = '0;
        req_bit   = '0;
        req_last  = '0;
        repeat (3) @(negedge CLK);
        check("rst_grant", grant, 0);
        check("rst_ready", req_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done_valid", done_valid, 0);
        check("rst_done_id", done_id, 0);
        check("rst_done_count", done_count, 0);
        check("rst_done_timeout", done_timeout, 0);
        RST = 1'b1;
        @(negedge CLK);

        // Single-bit burst latency
        req_valid[0] = 1'b1; req_bit[0] = 1'b1; req_last[0] = 1'b1;
        @(negedge CLK);
        check("lat_grant", grant, 4'b0001);
        check("lat_ready", req_ready, 4'b0001);
        check("lat_no_done_yet", done_valid, 0);
        @(negedge CLK);
        req_valid[0] = 1'b0; req_last[0] = 1'b0;
        check("lat_done_valid", done_valid, 1);
        check("lat_done_count", done_count, 0);
        check("lat_done_id", done_id, 0);
        check("lat_grant_drop", grant, 0);
        @(negedge CLK);
        check("lat_done_pulse_end", done_valid, 0);
        check("lat_idle", busy, 0);

        // Req0 burst 1,1,0,0,1,0
        base = done_n;
        send_bit(0, 1, 0); send_bit(0, 1, 0); send_bit(0, 0, 0);
        send_bit(0, 0, 0); send_bit(0, 1, 0); send_bit(0, 0, 1);
        wait_done(base + 1);
        repeat (3) @(negedge CLK);
        check("b1_done_n", done_n, base + 1);
        check("b1_id", d_id[base], 0);
        check("b1_count", d_cnt[base], 1);
        check("b1_timeout", d_to[base], 0);
        check("b1_hold_count", done_count, 1);

        // Req1 and req2 simultaneously
        base = done_n;
        fork
            begin
                send_bit(1, 1, 0); send_bit(1, 0, 1);
            end
            begin
                send_bit(2, 1, 0); send_bit(2, 0, 0); send_bit(2, 0, 0);
                send_bit(2, 1, 0); send_bit(2, 1, 0); send_bit(2, 0, 1);
            end
        join
        wait_done(base + 2);
        repeat (3) @(negedge CLK);
        check("rr_done_n", done_n, base + 2);
        check("rr_first_id", d_id[base], 1);
        check("rr_first_count", d_cnt[base], 1);
        check("rr_second_id", d_id[base + 1], 2);
        check("rr_second_count", d_cnt[base + 1], 2);

        // Req3 saturating count
        base = done_n;
        for (int i = 0; i < 20; i++) begin
            send_bit(3, 1, 0);
            send_bit(3, 0, 0);
            send_bit(3, 1, (i == 19) ? 1'b1 : 1'b0);
        end
        wait_done(base + 1);
        repeat (3) @(negedge CLK);
        check("sat_done_n", done_n, base + 1);
        check("sat_id", d_id[base], 3);
        check("sat_count", d_cnt[base], 15);

        // Reset during req0's fourth bit
        base = done_n;
        send_bit(0, 1, 0); send_bit(0, 1, 0); send_bit(0, 0, 0);
        req_valid[0] = 1'b1; req_bit[0] = 1'b0;
        check("mid_rst_granted", grant, 4'b0001);
        RST = 1'b0;
        @(negedge CLK);
        check("mid_rst_grant", grant, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", req_ready, 0);
        req_valid = '0;
        RST = 1'b1;
        repeat (12) @(negedge CLK);
        check("mid_rst_no_done", done_n, base);
        check("mid_rst_done_count", done_count, 0);

        // Req2 stalls after 1,0
        base = done_n;
        send_bit(2, 1, 0); send_bit(2, 0, 0);
`ifdef DETECT_TIMEOUT_EN
        wait_done(base + 1);
        repeat (2) @(negedge CLK);
        check("to_done_n", done_n, base + 1);
        check("to_id", d_id[base], 2);
        check("to_count", d_cnt[base], 1);
        check("to_flag", d_to[base], 1);
        check("to_idle", busy, 0);
`else
        repeat (20) @(negedge CLK);
        check("stall_grant", grant, 4'b0100);
        check("stall_busy", busy, 1);
        check("stall_no_done", done_n, base);
        send_bit(2, 0, 1);
        wait_done(base + 1);
        repeat (2) @(negedge CLK);
        check("stall_done_n", done_n, base + 1);
        check("stall_count", d_cnt[base], 1);
        check("stall_timeout", d_to[base], 0);
`endif

        check("grant_onehot", {31'd0, overlap}, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
